// File: rtl/reg_wb_ctrl_pkg.sv
// Shared widths and constants for the register-file write-back controller.
package reg_wb_ctrl_pkg;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NREGS = 2 ** AW;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_FIFO = 2'd2
    } wb_src_e;

endpackage

// File: rtl/reg_wb_ctrl_if.sv
// Producer/result and register-file write-port bundle of the write-back controller.
interface reg_wb_ctrl_if #(
    parameter int AW = reg_wb_ctrl_pkg::AW,
    parameter int DW = reg_wb_ctrl_pkg::DW
);
    logic                 alu_valid;
    logic [AW-1:0]        alu_rd;
    logic [DW-1:0]        alu_data;
    logic                 mem_valid;
    logic                 mem_ready;
    logic [AW-1:0]        mem_rd;
    logic [DW-1:0]        mem_data;
    logic [AW-1:0]        rw;
    logic [DW-1:0]        busw;
    logic                 we;
    logic [2**AW-1:0]     pend_mask;
    logic                 ovf_err;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  mem_ready, rw, busw, we, pend_mask, ovf_err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output mem_ready, rw, busw, we, pend_mask, ovf_err
    );
endinterface

// File: rtl/reg_wb_ctrl_wb_fifo.sv
// Circular buffer for memory results; an extra pointer MSB separates full from empty.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem_r [DEPTH];
    logic [PW:0]  wp_r;
    logic [PW:0]  rp_r;
    logic         push_ok_s;
    logic         pop_ok_s;

    // Occupancy flags and guarded push/pop strobes.
    always_comb begin
        empty     = (wp_r == rp_r);
        full      = (wp_r[PW] != rp_r[PW]) && (wp_r[PW-1:0] == rp_r[PW-1:0]);
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
        head      = mem_r[rp_r[PW-1:0]];
    end

    // Pointer registers; reset discards every queued entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_r <= '0;
            rp_r <= '0;
        end else begin
            if (push_ok_s) wp_r <= wp_r + 1'b1;
            if (pop_ok_s)  rp_r <= rp_r + 1'b1;
        end
    end

    // Entry storage, written at the write pointer.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_r[wp_r[PW-1:0]] <= wdata;
    end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file write-back controller: ALU results win, memory results are queued.
module reg_wb_ctrl #(
    parameter int DEPTH = 4,
    parameter int DW    = reg_wb_ctrl_pkg::DW,
    parameter int AW    = reg_wb_ctrl_pkg::AW
) (
    input  logic            clk,
    input  logic            rst,
    reg_wb_ctrl_if.slave    bus
);
    import reg_wb_ctrl_pkg::*;

    localparam int NR = 2 ** AW;
    localparam logic [NR-1:0] BIT0 = {{(NR-1){1'b0}}, 1'b1};

    logic [AW+DW-1:0] head_s;
    logic             full_s;
    logic             empty_s;
    logic             mem_ready_s;
    logic             alu_take_s;
    logic             mem_fire_s;
    logic             push_s;
    logic             pop_s;
    logic             viol_s;
    logic [NR-1:0]    set_s;
    logic [NR-1:0]    clr_s;
    logic [NR-1:0]    pend_next_s;

    logic             we_r;
    logic [AW-1:0]    rw_r;
    logic [DW-1:0]    busw_r;
    wb_src_e          src_r;
    logic [NR-1:0]    pend_r;
    logic             ovf_r;

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + DW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .wdata ({bus.mem_rd, bus.mem_data}),
        .pop   (pop_s),
        .head  (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign mem_ready_s = !rst && !full_s;

    // Arbitration, pending-mask update and contract checks for this cycle.
    always_comb begin
        alu_take_s = bus.alu_valid && (bus.alu_rd != REG_ZERO);
        mem_fire_s = bus.mem_valid && mem_ready_s;
        push_s     = mem_fire_s && (bus.mem_rd != REG_ZERO);
        pop_s      = !alu_take_s && !empty_s;
        set_s      = {NR{1'b0}};
        clr_s      = {NR{1'b0}};
        if (push_s) begin
            set_s = BIT0 << bus.mem_rd;
        end else begin
            set_s = {NR{1'b0}};
        end
        // Clear lands on the same edge the register file commits the queued write.
        if (we_r && (src_r == SRC_FIFO)) begin
            clr_s = BIT0 << rw_r;
        end else begin
            clr_s = {NR{1'b0}};
        end
        pend_next_s = ((pend_r & ~clr_s) | set_s) & ~BIT0;
        viol_s      = (push_s && pend_r[bus.mem_rd]) ||
                      (alu_take_s && pend_r[bus.alu_rd]);
    end

    // Write-port output register, pending mask and sticky violation flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_r   <= 1'b0;
            rw_r   <= {AW{1'b0}};
            busw_r <= {DW{1'b0}};
            src_r  <= SRC_NONE;
            pend_r <= {NR{1'b0}};
            ovf_r  <= 1'b0;
        end else begin
            if (alu_take_s) begin
                we_r   <= 1'b1;
                rw_r   <= bus.alu_rd;
                busw_r <= bus.alu_data;
                src_r  <= SRC_ALU;
            end else if (pop_s) begin
                we_r   <= 1'b1;
                rw_r   <= head_s[AW+DW-1:DW];
                busw_r <= head_s[DW-1:0];
                src_r  <= SRC_FIFO;
            end else begin
                we_r   <= 1'b0;
                src_r  <= SRC_NONE;
            end
            pend_r <= pend_next_s;
            if (viol_s) ovf_r <= 1'b1;
        end
    end

    assign bus.mem_ready = mem_ready_s;
    assign bus.we        = we_r;
    assign bus.rw        = rw_r;
    assign bus.busw      = busw_r;
    assign bus.pend_mask = pend_r;
    assign bus.ovf_err   = ovf_r;

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed self-checking bench for reg_wb_ctrl with hand-computed expectations.
module tb_reg_wb_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    reg_wb_ctrl_if bus ();

    reg_wb_ctrl #(.DEPTH(4), .DW(32), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'h0;
        bus.mem_valid = 1'b0; bus.mem_rd = 5'd0; bus.mem_data = 32'h0;

        step();
        check("rst_we", {31'd0, bus.we}, 32'd0);
        check("rst_mem_ready", {31'd0, bus.mem_ready}, 32'd0);
        step();
        #2 rst = 1'b0;
        step();
        check("idle_we", {31'd0, bus.we}, 32'd0);
        check("idle_rw", {27'd0, bus.rw}, 32'd0);
        check("idle_busw", bus.busw, 32'd0);
        check("idle_pend", bus.pend_mask, 32'd0);
        check("idle_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
        check("idle_ovf", {31'd0, bus.ovf_err}, 32'd0);

        // ALU alone
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
        step();
        bus.alu_valid = 1'b0;
        check("alu_we", {31'd0, bus.we}, 32'd1);
        check("alu_rw", {27'd0, bus.rw}, 32'd5);
        check("alu_busw", bus.busw, 32'h1234);
        step();
        check("alu_we_off", {31'd0, bus.we}, 32'd0);
        check("alu_rw_hold", {27'd0, bus.rw}, 32'd5);

        // Memory alone
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'hDEAD;
        step();
        bus.mem_valid = 1'b0;
        check("mem_pend_n1", bus.pend_mask, 32'h0000_0080);
        check("mem_we_n1", {31'd0, bus.we}, 32'd0);
        step();
        check("mem_we_n2", {31'd0, bus.we}, 32'd1);
        check("mem_rw_n2", {27'd0, bus.rw}, 32'd7);
        check("mem_busw_n2", bus.busw, 32'hDEAD);
        check("mem_pend_n2", bus.pend_mask, 32'h0000_0080);
        step();
        check("mem_pend_n3", bus.pend_mask, 32'd0);
        check("mem_we_n3", {31'd0, bus.we}, 32'd0);

        // Contention: six ALU writes, four memory beats filling the FIFO
        for (int k = 0; k < 6; k++) begin
            if (k >= 1) begin
                check("cont_alu_we", {31'd0, bus.we}, 32'd1);
                check("cont_alu_rw", {27'd0, bus.rw}, 32'(10 + k - 1));
                check("cont_alu_busw", bus.busw, 32'(32'hA0 + k - 1));
            end
            if (k < 4) begin
                check("cont_ready", {31'd0, bus.mem_ready}, 32'd1);
                bus.mem_valid = 1'b1;
                bus.mem_rd    = 5'(1 + k);
                bus.mem_data  = 32'(32'hB0 + k);
            end else begin
                check("cont_full", {31'd0, bus.mem_ready}, 32'd0);
                bus.mem_valid = 1'b0;
            end
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 5'(10 + k);
            bus.alu_data  = 32'(32'hA0 + k);
            step();
        end
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
        check("cont_alu_last", {27'd0, bus.rw}, 32'd15);
        check("cont_pend", bus.pend_mask, 32'h0000_001E);
        step();
        for (int k = 0; k < 4; k++) begin
            check("cont_mem_we", {31'd0, bus.we}, 32'd1);
            check("cont_mem_rw", {27'd0, bus.rw}, 32'(1 + k));
            check("cont_mem_busw", bus.busw, 32'(32'hB0 + k));
            step();
        end
        check("cont_pend_clr", bus.pend_mask, 32'd0);
        check("cont_we_off", {31'd0, bus.we}, 32'd0);
        check("cont_ready_back", {31'd0, bus.mem_ready}, 32'd1);

        // x0 memory beat is accepted but dropped
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'h55;
        check("x0_ready", {31'd0, bus.mem_ready}, 32'd1);
        step();
        bus.mem_valid = 1'b0;
        check("x0_pend", bus.pend_mask, 32'd0);
        check("x0_we_n1", {31'd0, bus.we}, 32'd0);
        step();
        check("x0_we_n2", {31'd0, bus.we}, 32'd0);
        step();
        check("x0_we_n3", {31'd0, bus.we}, 32'd0);

        // Second beat to pending x3 raises the sticky violation flag
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd3; bus.mem_data = 32'h33;
        step();
        bus.mem_data = 32'h44;
        check("ovf_pre", {31'd0, bus.ovf_err}, 32'd0);
        check("ovf_pend3", bus.pend_mask, 32'h0000_0008);
        step();
        bus.mem_valid = 1'b0;
        check("ovf_set", {31'd0, bus.ovf_err}, 32'd1);
        check("ovf_first_busw", bus.busw, 32'h33);
        step();
        check("ovf_second_busw", bus.busw, 32'h44);
        check("ovf_second_we", {31'd0, bus.we}, 32'd1);
        step();
        step();
        step();
        check("ovf_sticky", {31'd0, bus.ovf_err}, 32'd1);
        check("ovf_idle_we", {31'd0, bus.we}, 32'd0);

        // Reset while three entries are queued
        for (int k = 0; k < 3; k++) begin
            check("mid_ready", {31'd0, bus.mem_ready}, 32'd1);
            bus.alu_valid = 1'b1; bus.alu_rd = 5'(20 + k); bus.alu_data = 32'(k);
            bus.mem_valid = 1'b1;
            bus.mem_rd    = (k == 0) ? 5'd6 : ((k == 1) ? 5'd8 : 5'd9);
            bus.mem_data  = 32'(32'hC0 + k);
            step();
        end
        bus.mem_valid = 1'b0;
        bus.alu_rd = 5'd23; bus.alu_data = 32'h3;
        check("mid_pend", bus.pend_mask, 32'h0000_0340);
        check("mid_we", {31'd0, bus.we}, 32'd1);
        check("mid_rw", {27'd0, bus.rw}, 32'd22);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_we", {31'd0, bus.we}, 32'd0);
        check("mid_rst_pend", bus.pend_mask, 32'd0);
        check("mid_rst_ready", {31'd0, bus.mem_ready}, 32'd0);
        check("mid_rst_ovf", {31'd0, bus.ovf_err}, 32'd0);
        check("mid_rst_rw", {27'd0, bus.rw}, 32'd0);
        bus.alu_valid = 1'b0;
        step();
        #2 rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check("post_rst_we", {31'd0, bus.we}, 32'd0);
            check("post_rst_pend", bus.pend_mask, 32'd0);
        end
        check("post_rst_ready", {31'd0, bus.mem_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_wb_ctrl.md
Name: reg_wb_ctrl

Overview:
- Write-side controller for the 32x32 register file; it is the only driver of the file's write port (rw, busw, we).
- Merges two result producers: a single-cycle ALU, which has priority, and a multi-cycle load/memory unit, whose results are buffered in a small FIFO.
- Exports a pending-destination mask so decode can stall on registers with queued writes.

Parameters:
- DEPTH, 4, memory-result FIFO entries (power of two, ≥2)
- DW, 32, data width
- AW, 5, register address width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- alu_valid  in  1  ALU result valid this cycle (no backpressure)
- alu_rd  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- mem_valid  in  1  memory result offered
- mem_ready  out  1  FIFO can accept; a beat transfers when mem_valid&&mem_ready
- mem_rd  in  AW  memory destination register
- mem_data  in  DW  memory result
- rw  out  AW  register file write address
- busw  out  DW  register file write data
- we  out  1  register file write enable
- pend_mask  out  2**AW  bit i=1: a memory write to register i is queued or on the write port
- ovf_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset, asynchronous and active-high: we=0, rw=0, busw=0, FIFO emptied, pend_mask=0, ovf_err=0, mem_ready=0 while rst=1. Queued writes are discarded, including on reset mid-operation.
- mem_ready = !rst && (FIFO not full). It is combinational from registered state and never depends on mem_valid.
- Write port outputs are registered. Per cycle N, evaluated at the edge ending N:
  - If alu_valid and alu_rd!=0: drive ALU result in N+1.
  - Else if FIFO non-empty: pop the head and drive it in N+1.
  - Else: we=0 in N+1; rw and busw hold their values.
- The ALU always wins; FIFO entries wait with no starvation limit.
- Latency:
  - ALU: we high the cycle after alu_valid.
  - Memory: accepted in N; earliest we in N+2 (push at end of N, pop decision in N+1).
- Writes to x0 are dropped:
  - alu_rd=0 produces we=0.
  - A memory beat with mem_rd=0 is accepted (handshake completes) but not pushed, and does not set pend_mask.
- FIFO is circular with ptr width log2(DEPTH)+1. Full and empty are distinguished by the MSB. Push and pop in the same cycle are legal at any occupancy, including full (mem_ready=0 when full, so no push occurs then).
- pend_mask[i]:
  - Set at the edge where a beat with mem_rd=i is pushed.
  - Cleared at the edge ending the cycle in which we=1, rw=i, and the write came from the FIFO; this is the same edge at which the register file commits.
  - A set and a clear on different bits in one cycle both apply.
- Upstream contract:
  - No mem beat with mem_rd whose pend_mask bit is already set.
  - No alu_valid with alu_rd whose pend_mask bit is set.
  - Either violation sets ovf_err=1 until reset. The offending write still proceeds, with ordering unspecified.
- pend_mask[0] is always 0.

Decomposition:
- Shared package: DW and AW constants, register count 2**AW, and the x0 address constant (REG_ZERO=0).
- One natural sub-module: wb_fifo (DEPTH×(AW+DW) circular buffer with push, pop, full, empty, and head outputs).
- Arbitration, pend_mask, and the output register stay in reg_wb_ctrl.

Test Plan:
- Reset, then idle → we=0, rw=0, busw=0, pend_mask=0, mem_ready=1 after rst falls.
- ALU alone: alu_valid with rd=5, data=0x1234 in cycle N → cycle N+1 shows we=1, rw=5, busw=0x1234; we=0 in N+2.
- Memory alone: beat rd=7, data=0xDEAD accepted in N → pend_mask[7]=1 from N+1; we=1, rw=7 in N+2; pend_mask[7]=0 from N+3.
- Contention: DEPTH=4 memory beats (rd 1–4) accepted while alu_valid is held 6 cycles (rd 10–15) → mem_ready falls after the 4th push. ALU writes appear in order on consecutive cycles, then memory writes rd 1,2,3,4 in order; pend_mask returns to 0.
- Boundaries:
  - Memory beat rd=0 → handshake completes, no we, pend_mask unchanged.
  - Second memory beat to pending rd=3 → ovf_err=1 and stays high.
- Reset mid-operation: FIFO holding 3 entries, rst pulsed asynchronously between edges → we=0 immediately, pend_mask=0, and no queued write ever appears after release.
